// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - shared XLEN package and the fetch-unit bus interface (redirect, imem, decode)
package riscv_pkg;
    parameter int XLEN = 32;
endpackage

interface ifetch_if;
    logic                       branch_v_i;
    logic [riscv_pkg::XLEN-1:0] pc_nxt_i;
    logic                       imem_req_o;
    logic [riscv_pkg::XLEN-1:0] imem_addr_o;
    logic                       imem_gnt_i;
    logic                       imem_rvalid_i;
    logic [riscv_pkg::XLEN-1:0] imem_rdata_i;
    logic                       dec_v_o;
    logic [riscv_pkg::XLEN-1:0] dec_instr_o;
    logic [riscv_pkg::XLEN-1:0] dec_pc_o;
    logic                       dec_ready_i;

    modport master (
        input  branch_v_i, pc_nxt_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, dec_ready_i,
        output imem_req_o, imem_addr_o, dec_v_o, dec_instr_o, dec_pc_o
    );

    modport slave (
        output branch_v_i, pc_nxt_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, dec_ready_i,
        input  imem_req_o, imem_addr_o, dec_v_o, dec_instr_o, dec_pc_o
    );
endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: PC register, single-outstanding imem request FSM, 2-entry decode FIFO
module ifetch #(
    parameter int                  XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]     RESET_VECTOR = '0
) (
    input  logic  clk,
    input  logic  reset_n,
    ifetch_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DROP} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] fifo_pc    [2];
    logic [XLEN-1:0] fifo_instr [2];
    logic            head;
    logic [1:0]      count;

    logic            req;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            grant;
    logic            push;
    logic            pop;
    logic            wr_slot;

    // Only FETCH requests, and FETCH never has a response pending, so occupancy alone gates it.
    assign req         = (state == FETCH) && (count < 2'd2);
    assign redirect    = bus.branch_v_i;
    assign redirect_pc = bus.pc_nxt_i & ~XLEN'(3);
    assign grant       = req && bus.imem_gnt_i;
    assign push        = (state == WAIT) && bus.imem_rvalid_i && !redirect;
    assign pop         = (count != 2'd0) && bus.dec_ready_i && !redirect;
    assign wr_slot     = head ^ count[0];

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc;
    assign bus.dec_v_o     = (count != 2'd0);
    assign bus.dec_instr_o = fifo_instr[head];
    assign bus.dec_pc_o    = fifo_pc[head];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pc    <= RESET_VECTOR;
            tag   <= '0;
            head  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_pc[wr_slot]    <= tag;
                fifo_instr[wr_slot] <= bus.imem_rdata_i;
            end

            if (redirect) begin
                head  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (pop) begin
                    head <= ~head;
                end
                count <= count + 2'(push) - 2'(pop);
            end

            if (redirect) begin
                pc <= redirect_pc;
            end else if (grant) begin
                pc <= pc + XLEN'(4);
            end

            if (grant) begin
                tag <= pc;
            end

            // A grant coinciding with a redirect still owes a response, which DROP swallows.
            case (state)
                IDLE:  state <= FETCH;
                FETCH: if (grant) state <= redirect ? DROP : WAIT;
                WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        state <= FETCH;
                    end else if (redirect) begin
                        state <= DROP;
                    end
                end
                DROP:  if (bus.imem_rvalid_i) state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed bench for ifetch with a latency-programmable imem model and decode scoreboard
module tb_ifetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_if bus();

    ifetch #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int          n_chk = 0;
    int          n_err = 0;
    ent_t        exp_q[$];

    bit          gnt_en = 1'b0;
    bit          rdy    = 1'b0;
    bit          br_req = 1'b0;
    logic [31:0] br_tgt = '0;
    int          lat    = 1;

    bit          pend      = 1'b0;
    bit          pend_drop = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt  = 0;
    logic [31:0] exp_pc    = '0;
    int          n_grant   = 0;
    int          n_pop     = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) + 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge: drive inputs for the next rising edge, predict its effects, return at the next falling edge.
    task automatic step();
        logic rv;
        ent_t e;
        int   occ;
        rv = pend && (pend_cnt == 0);
        if (pend && pend_cnt != 0) pend_cnt--;
        bus.imem_gnt_i    = gnt_en;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rv ? mem_word(pend_addr) : 32'h0;
        bus.dec_ready_i   = rdy;
        bus.branch_v_i    = br_req;
        bus.pc_nxt_i      = br_tgt;

        if (bus.imem_req_o) begin
            occ = exp_q.size() + int'(pend);
            chk("req_room", 32'(occ < 2), 32'd1);
            chk("req_addr", bus.imem_addr_o, exp_pc);
        end
        if (bus.dec_v_o && rdy && !br_req) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", bus.dec_v_o, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("dec_pc", bus.dec_pc_o, e.pc);
                chk("dec_instr", bus.dec_instr_o, e.instr);
            end
        end
        if (rv) begin
            if (!pend_drop && !br_req) begin
                e.pc    = pend_addr;
                e.instr = mem_word(pend_addr);
                exp_q.push_back(e);
            end
            pend = 1'b0;
        end
        if (br_req && pend) pend_drop = 1'b1;
        if (bus.imem_req_o && gnt_en) begin
            n_grant++;
            pend      = 1'b1;
            pend_addr = exp_pc;
            pend_cnt  = lat - 1;
            pend_drop = br_req;
            if (!br_req) exp_pc = exp_pc + 32'd4;
        end
        if (br_req) begin
            exp_q.delete();
            exp_pc = br_tgt & ~32'h3;
        end
        br_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_req", bus.imem_req_o, 32'd0);
        chk("rst_dec_v", bus.dec_v_o, 32'd0);
        chk("rst_dec_instr", bus.dec_instr_o, 32'd0);
        chk("rst_dec_pc", bus.dec_pc_o, 32'd0);
        exp_q.delete();
        if (pend) pend_drop = 1'b1;
        exp_pc  = 32'h0;
        n_grant = 0;
        n_pop   = 0;
        step();
        reset_n = 1'b1;
        chk("release_req_idle", bus.imem_req_o, 32'd0);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr, input int bound);
        for (int i = 0; i < bound && !(bus.imem_req_o && bus.imem_addr_o == addr); i++) step();
        chk({tag, "_req"}, bus.imem_req_o, 32'd1);
        chk({tag, "_addr"}, bus.imem_addr_o, addr);
    endtask

    task automatic wait_any_req(input int bound);
        for (int i = 0; i < bound && !bus.imem_req_o; i++) step();
    endtask

    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.dec_ready_i   = 1'b0;
        bus.branch_v_i    = 1'b0;
        bus.pc_nxt_i      = '0;
        @(negedge clk);

        // Streaming: gnt always, one-cycle latency, decode always ready.
        gnt_en = 1'b1; lat = 1; rdy = 1'b1;
        do_reset();
        step();
        chk("first_req", bus.imem_req_o, 32'd1);
        chk("first_addr", bus.imem_addr_o, 32'h0);
        repeat (20) step();
        chk("stream_progress", 32'(n_pop >= 8), 32'd1);

        // Backpressure: two entries buffered, request withheld, then drained in order.
        rdy = 1'b0;
        do_reset();
        repeat (12) step();
        chk("full_dec_v", bus.dec_v_o, 32'd1);
        chk("full_req", bus.imem_req_o, 32'd0);
        chk("full_grants", 32'(n_grant), 32'd2);
        chk("full_head", bus.dec_pc_o, 32'h0);
        rdy = 1'b1;
        step();
        chk("drain_head", bus.dec_pc_o, 32'h4);
        repeat (4) step();

        // Redirect while waiting on 0x8; its response three cycles later is dropped.
        do_reset();
        wait_req("t3_reach8", 32'h8, 20);
        lat = 4;
        step();
        chk("t3_wait_req", bus.imem_req_o, 32'd0);
        br_req = 1'b1; br_tgt = 32'h100;
        step();
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_drop_req", bus.imem_req_o, 32'd0);
            step();
        end
        chk("t3_redir_req", bus.imem_req_o, 32'd1);
        chk("t3_redir_addr", bus.imem_addr_o, 32'h100);
        repeat (6) step();

        // Redirect coincident with the response for 0xC: no push, no DROP cycle.
        do_reset();
        wait_req("t4_reachc", 32'hC, 20);
        lat = 2;
        step();
        step();
        br_req = 1'b1; br_tgt = 32'h200;
        step();
        chk("t4_flush", bus.dec_v_o, 32'd0);
        chk("t4_req", bus.imem_req_o, 32'd1);
        chk("t4_addr", bus.imem_addr_o, 32'h200);
        lat = 1;
        repeat (6) step();

        // PC wraps past all-ones; low target bits are ignored.
        br_req = 1'b1; br_tgt = 32'hFFFF_FFFE;
        step();
        wait_req("t5_top", 32'hFFFF_FFFC, 10);
        step();
        wait_any_req(10);
        chk("t5_wrap_req", bus.imem_req_o, 32'd1);
        chk("t5_wrap_addr", bus.imem_addr_o, 32'h0);
        repeat (4) step();
        br_req = 1'b1; br_tgt = 32'h0000_0103;
        step();
        wait_any_req(10);
        chk("t5_mask_req", bus.imem_req_o, 32'd1);
        chk("t5_mask_addr", bus.imem_addr_o, 32'h100);
        repeat (4) step();

        // Reset with a request outstanding; its late response must not be pushed.
        wait_any_req(10);
        lat = 5;
        step();
        gnt_en = 1'b0;
        step();
        do_reset();
        step();
        chk("t6_first_req", bus.imem_req_o, 32'd1);
        chk("t6_first_addr", bus.imem_addr_o, 32'h0);
        step();
        step();
        chk("t6_late_ignored", bus.dec_v_o, 32'd0);
        lat = 1;
        gnt_en = 1'b1;
        step();
        step();
        chk("t6_fetch_v", bus.dec_v_o, 32'd1);
        chk("t6_fetch_pc", bus.dec_pc_o, 32'h0);
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter XLEN, 32, data/address width; the value comes from the riscv package.
REQ-002 Parameter RESET_VECTOR, 32'h0000_0000, the first PC fetched after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 branch_v_i  input  1  redirect request from the branch unit in execute.
REQ-006 pc_nxt_i  input  XLEN  redirect target; sampled only when branch_v_i=1.
REQ-007 imem_req_o  output  1  instruction-memory request valid.
REQ-008 imem_addr_o  output  XLEN  request address (the fetch PC).
REQ-009 imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-010 imem_rvalid_i  input  1  read data valid; latency from grant is one or more cycles.
REQ-011 imem_rdata_i  input  XLEN  instruction word.
REQ-012 dec_v_o  output  1  instruction valid to decode.
REQ-013 dec_instr_o  output  XLEN  instruction word to decode.
REQ-014 dec_pc_o  output  XLEN  PC of dec_instr_o.
REQ-015 dec_ready_i  input  1  decode accepts the head entry this cycle.

Function
REQ-016 The block SHALL keep a fetch PC register, a 2-entry FIFO of {pc, instr}, and an FSM with states IDLE, FETCH, WAIT and DROP.
REQ-017 The block SHALL allow at most one request outstanding (granted, no rvalid yet).
REQ-018 imem_req_o SHALL be 1 only in FETCH and only when (FIFO occupancy + outstanding) < 2.
REQ-019 Once imem_req_o is asserted, imem_addr_o SHALL stay stable until imem_gnt_i=1 or a redirect occurs.
REQ-020 On grant without redirect: the PC SHALL become PC+4 (mod 2^XLEN, wrapping at all-ones), the granted PC SHALL be held as the tag, and the FSM SHALL go FETCH->WAIT.
REQ-021 In WAIT with imem_rvalid_i=1: {tag, imem_rdata_i} SHALL be pushed into the FIFO and the FSM SHALL return to FETCH; a new request may issue in the same cycle if space rule REQ-018 holds.
REQ-022 The FIFO SHALL present its head on dec_*_o; an entry is popped when dec_v_o & dec_ready_i; a push and a pop in the same cycle on a full FIFO SHALL be legal, and occupancy SHALL be unchanged.
REQ-023 A redirect (branch_v_i=1) SHALL, in that cycle: load PC with pc_nxt_i, flush the FIFO (dec_v_o=0 next cycle), and cancel any same-cycle pop effect on state.
REQ-024 Redirect in FETCH or IDLE SHALL go to FETCH; a request granted in the same cycle as the redirect SHALL be treated as stale.
REQ-025 Redirect with a request outstanding (WAIT, or a same-cycle grant) SHALL go to DROP; in DROP, imem_req_o=0 and the next rvalid SHALL be discarded, then the FSM goes to FETCH.
REQ-026 If rvalid and a redirect coincide in WAIT, the data SHALL be discarded and the FSM SHALL go to FETCH (not DROP).
REQ-027 Redirect in DROP SHALL update the PC and stay in DROP.
REQ-028 The PC register SHALL ignore bits [1:0] of pc_nxt_i by forcing them to 0.

Reset
REQ-029 While reset_n=0: FSM=IDLE, PC=RESET_VECTOR, FIFO empty, no outstanding request, imem_req_o=0, dec_v_o=0, dec_instr_o=0, dec_pc_o=0.
REQ-030 The first cycle after reset release SHALL move IDLE->FETCH; imem_req_o SHALL first assert in the following cycle.
REQ-031 Asserting reset mid-transaction SHALL abandon any outstanding response; an rvalid arriving after release while in IDLE/FETCH with nothing outstanding SHALL be ignored.

Verification
REQ-032 Reset release, gnt=1 always, rvalid 1 cycle after grant, dec_ready=1 -> addresses 0x0,0x4,0x8... are issued and decoded in order with matching dec_pc_o.
REQ-033 dec_ready_i=0 held -> exactly two entries are buffered, imem_req_o drops to 0, and no third request issues; releasing ready drains 0x0 then 0x4.
REQ-034 Redirect to 0x100 while WAIT for 0x8, rvalid 3 cycles later -> that data is dropped and the next request address is 0x100.
REQ-035 Redirect to 0x200 in the same cycle as rvalid for 0xC -> FIFO flushed, no push, the next request is 0x200 with no DROP cycle.
REQ-036 PC=0xFFFF_FFFC granted -> the next PC is 0x0000_0000; pc_nxt_i=0x0000_0103 -> the fetch address is 0x0000_0100.
REQ-037 Assert reset_n=0 with a request outstanding, release, then a late rvalid -> no FIFO push, and the first request goes to RESET_VECTOR.
